// File: rtl/rle_symbol_serializer.sv
// RLE symbol serializer: takes one packed RLE block per handshake and streams its
// symbols (slot 0 first) one per cycle, stopping at the EOB code or at the last slot.
module rle_symbol_serializer #(
   parameter int unsigned SYM_W = 14,
   parameter int unsigned NSYM  = 64,
   parameter logic [SYM_W-1:0] EOB = {SYM_W{1'b1}}
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SYM_W*NSYM-1:0]         blk_data,
   input  logic                          blk_valid,
   output logic                          blk_ready,
   output logic                          blk_drop,
   output logic [SYM_W-1:0]              sym_data,
   output logic                          sym_valid,
   input  logic                          sym_ready,
   output logic                          sym_last,
   output logic                          blk_done,
   output logic [$clog2(NSYM):0]         blk_nsym
);

   localparam int unsigned BLK_W = SYM_W * NSYM;
   localparam int unsigned IDX_W = $clog2(NSYM);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e             state_q, state_d;
   logic [BLK_W-1:0]   buf_q, buf_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   nsym_q, nsym_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;
   logic               sym_hs;

   // Output decode: symbol comes straight from the registered buffer head.
   always_comb begin
      sym_valid = (state_q == StEmit);
      sym_data  = buf_q[BLK_W-1 -: SYM_W];
      sym_last  = sym_valid && ((sym_data == EOB) || (idx_q == IDX_LAST));
      sym_hs    = sym_valid & sym_ready;
      // Ready again only in the cycle the final symbol leaves, allowing back-to-back blocks.
      blk_ready = ~sym_valid | (sym_ready & sym_last);
      blk_drop  = drop_q;
      blk_done  = done_q;
      blk_nsym  = nsym_q;
   end

   // Next-state: load, shift on handshake, finish block (optionally reloading).
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      nsym_d  = nsym_q;
      done_d  = 1'b0;
      drop_d  = blk_valid & ~blk_ready;
      unique case (state_q)
         StIdle: begin
            if (blk_valid) begin
               buf_d   = blk_data;
               idx_d   = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (sym_hs) begin
               if (sym_last) begin
                  done_d = 1'b1;
                  nsym_d = CNT_W'(idx_q) + CNT_W'(1);
                  if (blk_valid) begin
                     buf_d = blk_data;
                     idx_d = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  buf_d = {buf_q[BLK_W-SYM_W-1:0], {SYM_W{1'b0}}};
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         buf_q   <= '0;
         idx_q   <= '0;
         nsym_q  <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         nsym_q  <= nsym_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

endmodule
